// File: rtl/hydrophone_arrival_capture_if.sv
// Result bus of hydrophone_arrival_capture: one set of per-channel arrival
// timestamps handed downstream over a valid/ready handshake.
//   ts_valid : result valid (source -> sink)
//   ts_ready : sink accepts result (sink -> source)
//   ts_data  : packed relative arrival times, channel i at [i*TS_W +: TS_W]
//   ts_mask  : 1 = channel detected within the window
interface hydrophone_arrival_capture_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned TS_W = 16
);
    logic                 ts_valid;
    logic                 ts_ready;
    logic [N_CH*TS_W-1:0] ts_data;
    logic [N_CH-1:0]      ts_mask;

    modport master (
        output ts_valid,
        output ts_data,
        output ts_mask,
        input  ts_ready
    );

    modport slave (
        input  ts_valid,
        input  ts_data,
        input  ts_mask,
        output ts_ready
    );
endinterface

// File: rtl/hydrophone_arrival_capture.sv
// Detects the first threshold crossing of each hydrophone channel within one
// ping and reports arrival times relative to the earliest arrival.
//   clk, rst_n    : clock, asynchronous active-low reset
//   arm           : level, enables detection
//   threshold     : unsigned detection level
//   sample_valid  : one strobe per sample period (all channels together)
//   sample_data   : packed magnitudes, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   busy          : high in WINDOW, OUTPUT and HOLDOFF
//   ts_if         : result bus (ts_valid/ts_ready/ts_data/ts_mask), master side
// Optional build macro ARRIVAL_DEBOUNCE_EN: a crossing must persist for two
// consecutive samples; the timestamp is that of the first of the two.
module hydrophone_arrival_capture #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned WINDOW   = 2048,
    parameter int unsigned HOLDOFF  = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic [SAMPLE_W-1:0]      threshold,
    input  logic                     sample_valid,
    input  logic [N_CH*SAMPLE_W-1:0] sample_data,
    output logic                     busy,
    hydrophone_arrival_capture_if.master ts_if
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StListen  = 3'd1;
    localparam logic [2:0] StWindow  = 3'd2;
    localparam logic [2:0] StOutput  = 3'd3;
    localparam logic [2:0] StHoldoff = 3'd4;

    localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    // Last counter value before the bound is reached; the increment that
    // lands on WINDOW / HOLDOFF is the exit sample.
    localparam logic [TS_W-1:0]  WinLast  = TS_W'(WINDOW - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);

    logic [2:0]                 state_q, state_d;
    logic [TS_W-1:0]            sample_cnt_q, sample_cnt_d;
    logic [TS_W-1:0]            win_cnt_q, win_cnt_d;
    logic [HoldW-1:0]           hold_cnt_q, hold_cnt_d;
    logic [TS_W-1:0]            first_ts_q, first_ts_d;
    logic [N_CH-1:0][TS_W-1:0]  raw_ts_q, raw_ts_d;
    logic [N_CH-1:0]            captured_q, captured_d;

    logic [N_CH-1:0]            above;
    logic [N_CH-1:0]            hit;
    logic [TS_W-1:0]            hit_ts;
    logic                       all_capt;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            above[i] = sample_data[i*SAMPLE_W +: SAMPLE_W] >= threshold;
        end
    end

`ifdef ARRIVAL_DEBOUNCE_EN
    // One bit per channel: previous sample was at or above threshold.
    logic [N_CH-1:0] hist_q, hist_d;

    always_comb begin
        hit    = sample_valid ? (above & hist_q) : '0;
        hit_ts = sample_cnt_q - TS_W'(1);
        hist_d = hist_q;
        if (state_d == StListen && state_q != StListen) begin
            hist_d = '0;
        end else if (sample_valid && (state_q == StListen || state_q == StWindow)) begin
            hist_d = above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        hit    = sample_valid ? above : '0;
        hit_ts = sample_cnt_q;
    end
`endif

    assign all_capt = &(captured_q | hit);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_valid ? sample_cnt_q + TS_W'(1) : sample_cnt_q;
        win_cnt_d    = win_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        first_ts_d   = first_ts_q;
        raw_ts_d     = raw_ts_q;
        captured_d   = captured_q;

        case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StListen;
                end
            end
            StListen: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (|hit) begin
                    first_ts_d = hit_ts;
                    captured_d = hit;
                    win_cnt_d  = '0;
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (hit[i]) begin
                            raw_ts_d[i] = hit_ts;
                        end
                    end
                    state_d = (&hit) ? StOutput : StWindow;
                end
            end
            StWindow: begin
                if (sample_valid) begin
                    win_cnt_d = win_cnt_q + TS_W'(1);
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (hit[i] && !captured_q[i]) begin
                            raw_ts_d[i]   = hit_ts;
                            captured_d[i] = 1'b1;
                        end
                    end
                    if (all_capt || win_cnt_q == WinLast) begin
                        state_d = StOutput;
                    end
                end
            end
            StOutput: begin
                if (ts_if.ts_ready) begin
                    captured_d = '0;
                    if (HOLDOFF == 0) begin
                        state_d = arm ? StListen : StIdle;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (sample_valid) begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d = arm ? StListen : StIdle;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            win_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            first_ts_q   <= '0;
            raw_ts_q     <= '0;
            captured_q   <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            win_cnt_q    <= win_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            first_ts_q   <= first_ts_d;
            raw_ts_q     <= raw_ts_d;
            captured_q   <= captured_d;
        end
    end

    // Outputs decode straight from registered state, so they hold steady for
    // the whole OUTPUT stall and read zero everywhere else.
    always_comb begin
        ts_if.ts_valid = (state_q == StOutput);
        ts_if.ts_mask  = ts_if.ts_valid ? captured_q : '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ts_if.ts_data[i*TS_W +: TS_W] = (ts_if.ts_valid && captured_q[i]) ?
                                            raw_ts_q[i] - first_ts_q : '0;
        end
        busy = (state_q == StWindow) || (state_q == StOutput) || (state_q == StHoldoff);
    end

endmodule

// File: tb/tb_hydrophone_arrival_capture.sv
module tb_hydrophone_arrival_capture;
    localparam int NCh     = 4;
    localparam int SampleW = 12;
    localparam int TsW     = 8;
    localparam int Window  = 8;
    localparam int Holdoff = 6;
    localparam int TsMod   = 1 << TsW;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    arm = 1'b0;
    logic [SampleW-1:0]      thr = 12'd100;
    logic                    sv = 1'b0;
    logic [NCh*SampleW-1:0]  sdata = '0;
    logic                    busy;

    hydrophone_arrival_capture_if #(.N_CH(NCh), .TS_W(TsW)) tif ();

    hydrophone_arrival_capture #(
        .N_CH(NCh), .SAMPLE_W(SampleW), .TS_W(TsW), .WINDOW(Window), .HOLDOFF(Holdoff)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .threshold(thr), .sample_valid(sv),
        .sample_data(sdata), .busy(busy), .ts_if(tif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dut_xfers = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MIdle = 0, MListen = 1, MWindow = 2, MOutput = 3, MHold = 4;
    int m_mode = MIdle;
    int m_cnt = 0;
    int m_first = 0;
    int m_elapsed = 0;
    int m_hold_left = 0;
    bit m_capt[NCh];
    int m_raw[NCh];
    bit m_prev[NCh];

    task automatic model_reset();
        m_mode = MIdle; m_cnt = 0; m_first = 0; m_elapsed = 0; m_hold_left = 0;
        for (int i = 0; i < NCh; i++) begin
            m_capt[i] = 0; m_raw[i] = 0; m_prev[i] = 0;
        end
    endtask

    task automatic enter_listen_or_idle();
        m_mode = arm ? MListen : MIdle;
        if (arm) for (int i = 0; i < NCh; i++) m_prev[i] = 0;
    endtask

    task automatic model_step();
        bit above[NCh];
        bit det[NCh];
        int ts;
        bit any, all;
        for (int i = 0; i < NCh; i++) begin
            above[i] = sv && (sdata[i*SampleW +: SampleW] >= thr);
`ifdef ARRIVAL_DEBOUNCE_EN
            det[i] = above[i] && m_prev[i];
`else
            det[i] = above[i];
`endif
        end
`ifdef ARRIVAL_DEBOUNCE_EN
        ts = (m_cnt + TsMod - 1) % TsMod;
`else
        ts = m_cnt;
`endif
        case (m_mode)
            MIdle: if (arm) begin
                m_mode = MListen;
                for (int i = 0; i < NCh; i++) m_prev[i] = 0;
            end
            MListen: if (!arm) m_mode = MIdle;
                else if (sv) begin
                    any = 0; all = 1;
                    for (int i = 0; i < NCh; i++) begin
                        any |= det[i]; all &= det[i]; m_prev[i] = above[i];
                    end
                    if (any) begin
                        m_first = ts; m_elapsed = 0;
                        for (int i = 0; i < NCh; i++) begin
                            m_capt[i] = det[i];
                            if (det[i]) m_raw[i] = ts;
                        end
                        m_mode = all ? MOutput : MWindow;
                    end
                end
            MWindow: if (sv) begin
                m_elapsed++;
                all = 1;
                for (int i = 0; i < NCh; i++) begin
                    if (det[i] && !m_capt[i]) begin
                        m_capt[i] = 1; m_raw[i] = ts;
                    end
                    all &= m_capt[i];
                    m_prev[i] = above[i];
                end
                if (all || m_elapsed == Window) m_mode = MOutput;
            end
            MOutput: if (tif.ts_ready) begin
                for (int i = 0; i < NCh; i++) m_capt[i] = 0;
                if (Holdoff == 0) enter_listen_or_idle();
                else begin
                    m_mode = MHold; m_hold_left = Holdoff;
                end
            end
            MHold: if (sv) begin
                m_hold_left--;
                if (m_hold_left == 0) enter_listen_or_idle();
            end
            default: m_mode = MIdle;
        endcase
        if (sv) m_cnt = (m_cnt + 1) % TsMod;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Single compare process: every negedge, DUT outputs against the model.
    initial begin
        logic [NCh*TsW-1:0] e_data;
        logic [NCh-1:0]     e_mask;
        logic               e_valid, e_busy;
        forever begin
            @(negedge clk);
            e_valid = (m_mode == MOutput);
            e_busy  = (m_mode == MWindow) || (m_mode == MOutput) || (m_mode == MHold);
            for (int i = 0; i < NCh; i++) begin
                e_mask[i] = e_valid && m_capt[i];
                e_data[i*TsW +: TsW] = e_mask[i] ? TsW'((m_raw[i] - m_first + TsMod) % TsMod)
                                                 : '0;
            end
            n_vec++;
            if (tif.ts_valid !== e_valid || busy !== e_busy || tif.ts_mask !== e_mask ||
                tif.ts_data !== e_data) begin
                n_err++;
                $display("FAIL cycle_compare @%0t: valid=%b busy=%b mask=%b data=%h, expected valid=%b busy=%b mask=%b data=%h",
                         $time, tif.ts_valid, busy, tif.ts_mask, tif.ts_data,
                         e_valid, e_busy, e_mask, e_data);
            end
            if (tif.ts_valid && tif.ts_ready) dut_xfers++;
        end
    end

    // ---------------- directed helpers ----------------
    function automatic int ch_ts(input int ch);
        logic [NCh*TsW-1:0] d;
        d = tif.ts_data;
        return int'(d[ch*TsW +: TsW]);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        sdata = '0; sv = 1'b1;
        while (m_cnt != target && n < 600) begin
            step(); n++;
        end
        if (m_cnt != target) chk("wait_cnt_timeout", m_cnt, target);
    endtask

    // Channel c goes (and stays) high from offset off[c]; ch1 also spikes at spike1.
    task automatic ping(input int start, input int o0, input int o1, input int o2, input int o3,
                        input int spike1, output int vcnt);
        int off[NCh];
        bit got = 0;
        off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
        vcnt = -1;
        wait_cnt(start);
        for (int k = 0; k < 40 && !got; k++) begin
            sv = 1'b1;
            for (int c = 0; c < NCh; c++) begin
                sdata[c*SampleW +: SampleW] =
                    ((off[c] >= 0 && k >= off[c]) || (c == 1 && k == spike1)) ? thr + 12'd50
                                                                               : thr / 2;
            end
            step();
            if (tif.ts_valid) begin
                got = 1; vcnt = m_cnt;
            end
        end
        sdata = '0;
        if (!got) chk("ping_timeout", 0, 1);
    endtask

    task automatic accept();
        tif.ts_ready = 1'b1;
        step();
        tif.ts_ready = 1'b0;
    endtask

    int vcnt, x0, held, nb;

    initial begin
        tif.ts_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(tif.ts_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_data", int'(tif.ts_data), 0);
        rst_n = 1'b1; arm = 1'b1; thr = 12'd100; sv = 1'b1;

        // Ping 1: crossings at 10, 13, 17, 12.
        ping(10, 0, 3, 7, 2, -1, vcnt);
`ifdef ARRIVAL_DEBOUNCE_EN
        chk("p1_latency", vcnt, 19);
`else
        chk("p1_latency", vcnt, 18);
`endif
        chk("p1_ch0", ch_ts(0), 0);
        chk("p1_ch1", ch_ts(1), 3);
        chk("p1_ch2", ch_ts(2), 7);
        chk("p1_ch3", ch_ts(3), 2);
        chk("p1_mask", int'(tif.ts_mask), 4'b1111);

        // Stall with crossings on every channel; result must not move.
        held = int'(tif.ts_data);
        sdata = '1; sv = 1'b1;
        repeat (20) step();
        chk("stall_valid", int'(tif.ts_valid), 1);
        chk("stall_data", int'(tif.ts_data), held);
        x0 = dut_xfers;
        accept();
        nb = 0;
        while (busy && nb < 50) begin
            step(); nb++;
        end
        chk("one_transfer", dut_xfers - x0, 1);
        chk("holdoff_busy_samples", nb, Holdoff);
        sdata = '0;

        // Window expiry: only ch0 (50) and ch2 (55).
        ping(50, 0, -1, 5, -1, -1, vcnt);
`ifdef ARRIVAL_DEBOUNCE_EN
        chk("p2_latency", vcnt, 60);
`else
        chk("p2_latency", vcnt, 59);
`endif
        chk("p2_ch0", ch_ts(0), 0);
        chk("p2_ch2", ch_ts(2), 5);
        chk("p2_ch1", ch_ts(1), 0);
        chk("p2_mask", int'(tif.ts_mask), 4'b0101);
        accept();

        // Counter wrap: ch0 at 254, ch1 at 3.
        ping(TsMod - 2, 0, 5, -1, -1, -1, vcnt);
        chk("wrap_ch1", ch_ts(1), 5);
        chk("wrap_mask", int'(tif.ts_mask), 4'b0011);
        accept();

        // Reset in the middle of a window.
        wait_cnt(100);
        sdata[0 +: SampleW] = thr + 12'd1;
        repeat (3) step();
        chk("mid_window_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_valid", int'(tif.ts_valid), 0);
        chk("async_reset_mask", int'(tif.ts_mask), 0);
        step();
        rst_n = 1'b1;
        ping(20, 0, 1, 1, 4, -1, vcnt);
        chk("fresh_ch1", ch_ts(1), 1);
        chk("fresh_ch3", ch_ts(3), 4);
        chk("fresh_mask", int'(tif.ts_mask), 4'b1111);
        accept();

`ifdef ARRIVAL_DEBOUNCE_EN
        // Isolated spike on ch1 at 60 must not count; real crossing at 70.
        ping(60, 5, 10, -1, -1, 0, vcnt);
        chk("deb_ch0", ch_ts(0), 0);
        chk("deb_ch1", ch_ts(1), 5);
        chk("deb_mask", int'(tif.ts_mask), 4'b0011);
        accept();
`endif

        // Randomized phase, checked cycle by cycle against the model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            arm = ($urandom_range(0, 99) < 95);
            if (cyc % 200 == 0) thr = 12'($urandom_range(500, 3500));
            sv = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NCh; c++) begin
                sdata[c*SampleW +: SampleW] = ($urandom_range(0, 99) < 6) ?
                    12'($urandom_range(int'(thr), 4095)) : 12'($urandom_range(0, int'(thr) - 1));
            end
            tif.ts_ready = ($urandom_range(0, 2) == 0);
            rst_n = (cyc % 997 != 500);
            step();
        end
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
